tile_match_engine: RTL
======================

// Module: tile_match_engine
// PURPOSE
//  Parametrised tile-matching game core. Generalises the in-game FSM to N_TILES tiles with per-game
//  colour tables, timed mismatch reveal, and protection against re-picking matched or duplicate tiles.
//  Sits between the debounced switch/key front end and the LED/HEX display drivers.
// PARAMETERS
//  N_TILES      10        number of tiles (even, 2..64); one select switch per tile
//  COLOR_W      4         tile colour id width (HEX-displayable at default)
//  SCORE_W      8         attempt counter width (saturating)
//  HOLD_CYCLES  100000000 mismatch reveal time in CLOCK_50 cycles (2 s); >=1
// PORTS
//  CLOCK_50     in   1                 system clock, all logic posedge
//  reset        in   1                 synchronous, active-high
//  start        in   1                 level: enter/restart game
//  quit         in   1                 level: abandon game
//  select       in   1                 one-cycle pulse: commit current sw pick / dismiss reveal
//  sw           in   N_TILES           tile select switches
//  tile_colors  in   N_TILES*COLOR_W   tile i colour at [i*COLOR_W +: COLOR_W]; latched on game entry
//  led_on       out  N_TILES           matched mask OR currently revealed picks
//  pick1_color  out  COLOR_W           first pick colour (0 when pick1_valid=0)
//  pick1_valid  out  1
//  pick2_color  out  COLOR_W           second pick colour (0 when pick2_valid=0)
//  pick2_valid  out  1
//  attempts     out  SCORE_W           pair evaluations this game, saturates at all-ones
//  pairs_left   out  $clog2(N_TILES/2+1)  unmatched pairs remaining
//  match_pulse  out  1                 1-cycle on successful pair
//  miss_pulse   out  1                 1-cycle on failed pair
//  game_over    out  1                 high in GAME_OVER
//  state        out  3                 current state encoding
// BEHAVIOUR
//  States: IDLE=0 ONE_TILE=1 HOLD=2 TWO_TILE=3 GAME_OVER=4 NOT_IN_GAME=5. All outputs registered.
//  reset: state=NOT_IN_GAME; led_on, picks, valids, attempts, pulses, game_over=0; pairs_left=N_TILES/2.
//  quit=1 in any state (priority over all else): next cycle = NOT_IN_GAME with reset values.
//  NOT_IN_GAME: start=1 -> latch tile_colors, clear matched mask/attempts, pairs_left=N_TILES/2, -> IDLE.
//  Pick rule: cand = sw & ~matched & ~pick1_mask; chosen = lowest set bit of cand.
//   select with cand==0 is ignored (no state change); select with no pulse does nothing.
//  IDLE: valid select -> pick1 = chosen, pick1_valid=1, -> ONE_TILE (1 cycle after select).
//  ONE_TILE: valid select -> pick2 = chosen, pick2_valid=1, -> TWO_TILE. Same tile as pick1 is never chosen.
//  TWO_TILE (exactly 1 cycle, evaluation): attempts+1 (hold at max).
//   colours equal: matched |= pick1|pick2, pairs_left-1, match_pulse=1, picks cleared;
//     -> GAME_OVER if pairs_left was 1, else IDLE.
//   colours differ: miss_pulse=1, hold counter=HOLD_CYCLES-1, -> HOLD (picks stay visible).
//  HOLD: counter decrements each cycle; counter==0 or select -> clear picks, -> IDLE.
//   select in HOLD is consumed as dismiss only, never as a new pick.
//  GAME_OVER: game_over=1, led_on=all ones, picks cleared; start=1 -> NOT_IN_GAME
//   (a held start then re-enters IDLE on the following cycle with a fresh game).
//  led_on = matched | pick1_mask | pick2_mask, updated same cycle as state change.
//  Pulses are never simultaneous; select in the TWO_TILE cycle is ignored.
//  tile_colors changes mid-game have no effect until next game entry.
//  Duplicate colour in >2 tiles is legal; any two equal-colour tiles match.
// TESTING
//  1 reset; start; sw=0x001 select, sw=0x080 select (colours equal) -> match_pulse, led_on=0x081,
//    attempts=1, pairs_left=4, state IDLE.
//  2 picks tiles 0,1 (differ) -> miss_pulse, state HOLD, led_on=0x003; after HOLD_CYCLES(=8 in sim)
//    cycles state IDLE, led_on=0x000; repeat with select at cycle 3 -> IDLE early.
//  3 after matching tile 0, sw=0x001 select -> ignored (state IDLE); sw=0x003 select -> picks tile 1.
//  4 in ONE_TILE with pick1=tile 2, sw=0x004 select -> ignored; sw=0x00C -> pick2=tile 3.
//  5 match all 5 pairs -> GAME_OVER, game_over=1, led_on=0x3FF; start -> NOT_IN_GAME -> IDLE, attempts=0.
//  6 quit asserted in HOLD and reset asserted in ONE_TILE -> next cycle NOT_IN_GAME, all outputs reset;
//    SCORE_W=2 bench: 5 misses -> attempts stays 3.

Source files
------------

// File: rtl/tile_match_engine.sv
// Tile-matching game core: N_TILES tiles, colours latched on game entry,
// pairs evaluated one cycle after the second pick, timed reveal on a miss.
// select is a one-cycle pulse sampled on CLOCK_50; it is acted on only in
// IDLE/ONE_TILE (pick, when a legal candidate exists) and HOLD (dismiss).
module tile_match_engine #(
    parameter int N_TILES     = 10,
    parameter int COLOR_W     = 4,
    parameter int SCORE_W     = 8,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         quit,
    input  logic                         select,
    input  logic [N_TILES-1:0]           sw,
    input  logic [N_TILES*COLOR_W-1:0]   tile_colors,
    output logic [N_TILES-1:0]           led_on,
    output logic [COLOR_W-1:0]           pick1_color,
    output logic                         pick1_valid,
    output logic [COLOR_W-1:0]           pick2_color,
    output logic                         pick2_valid,
    output logic [SCORE_W-1:0]           attempts,
    output logic [$clog2(N_TILES/2+1)-1:0] pairs_left,
    output logic                         match_pulse,
    output logic                         miss_pulse,
    output logic                         game_over,
    output logic [2:0]                   state
);

    localparam int PL_W   = $clog2(N_TILES/2+1);
    localparam int IDX_W  = $clog2(N_TILES);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PL_W-1:0]    PAIRS_INIT = PL_W'(N_TILES/2);
    localparam logic [PL_W-1:0]    PL_ONE     = PL_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLD_CYCLES-1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [N_TILES-1:0] LSB_ONE    = N_TILES'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ONE_TILE    = 3'd1,
        HOLD        = 3'd2,
        TWO_TILE    = 3'd3,
        GAME_OVER   = 3'd4,
        NOT_IN_GAME = 3'd5
    } state_t;

    state_t                       state_q;
    logic [N_TILES*COLOR_W-1:0]   colors_q;
    logic [N_TILES-1:0]           matched;
    logic [N_TILES-1:0]           pick1_mask;
    logic [N_TILES-1:0]           pick2_mask;
    logic [HOLD_W-1:0]            hold_cnt;

    logic [N_TILES-1:0]           cand;
    logic [N_TILES-1:0]           chosen;
    logic [IDX_W-1:0]             chosen_idx;
    logic [COLOR_W-1:0]           chosen_color;

    assign state = state_q;

    // Candidate pick: switches minus matched tiles minus the first pick; lowest wins.
    always_comb begin
        cand       = sw & ~matched & ~pick1_mask;
        chosen     = cand & (~cand + LSB_ONE);
        chosen_idx = '0;
        for (int i = N_TILES - 1; i >= 0; i--) begin
            if (cand[i]) chosen_idx = IDX_W'(i);
        end
        chosen_color = colors_q[int'(chosen_idx)*COLOR_W +: COLOR_W];
    end

    // Game FSM with all outputs registered; reset and quit share the out-of-game values.
    always_ff @(posedge CLOCK_50) begin
        if (reset || quit) begin
            state_q     <= NOT_IN_GAME;
            matched     <= '0;
            pick1_mask  <= '0;
            pick2_mask  <= '0;
            pick1_color <= '0;
            pick2_color <= '0;
            pick1_valid <= 1'b0;
            pick2_valid <= 1'b0;
            attempts    <= '0;
            pairs_left  <= PAIRS_INIT;
            match_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            game_over   <= 1'b0;
            led_on      <= '0;
            hold_cnt    <= '0;
        end else begin
            match_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            case (state_q)
                NOT_IN_GAME: begin
                    if (start) begin
                        colors_q   <= tile_colors;
                        matched    <= '0;
                        attempts   <= '0;
                        pairs_left <= PAIRS_INIT;
                        led_on     <= '0;
                        game_over  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                IDLE: begin
                    if (select && cand != '0) begin
                        pick1_mask  <= chosen;
                        pick1_color <= chosen_color;
                        pick1_valid <= 1'b1;
                        led_on      <= matched | chosen;
                        state_q     <= ONE_TILE;
                    end
                end
                ONE_TILE: begin
                    if (select && cand != '0) begin
                        pick2_mask  <= chosen;
                        pick2_color <= chosen_color;
                        pick2_valid <= 1'b1;
                        led_on      <= matched | pick1_mask | chosen;
                        state_q     <= TWO_TILE;
                    end
                end
                TWO_TILE: begin
                    if (attempts != '1) attempts <= attempts + SCORE_ONE;
                    if (pick1_color == pick2_color) begin
                        matched     <= matched | pick1_mask | pick2_mask;
                        pairs_left  <= pairs_left - PL_ONE;
                        match_pulse <= 1'b1;
                        pick1_mask  <= '0;
                        pick2_mask  <= '0;
                        pick1_color <= '0;
                        pick2_color <= '0;
                        pick1_valid <= 1'b0;
                        pick2_valid <= 1'b0;
                        if (pairs_left == PL_ONE) begin
                            game_over <= 1'b1;
                            led_on    <= '1;
                            state_q   <= GAME_OVER;
                        end else begin
                            led_on    <= matched | pick1_mask | pick2_mask;
                            state_q   <= IDLE;
                        end
                    end else begin
                        miss_pulse <= 1'b1;
                        hold_cnt   <= HOLD_INIT;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0 || select) begin
                        pick1_mask  <= '0;
                        pick2_mask  <= '0;
                        pick1_color <= '0;
                        pick2_color <= '0;
                        pick1_valid <= 1'b0;
                        pick2_valid <= 1'b0;
                        led_on      <= matched;
                        state_q     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        matched    <= '0;
                        attempts   <= '0;
                        pairs_left <= PAIRS_INIT;
                        game_over  <= 1'b0;
                        led_on     <= '0;
                        state_q    <= NOT_IN_GAME;
                    end
                end
                default: state_q <= NOT_IN_GAME;
            endcase
        end
    end

endmodule
